key_event_decoder: RTL and testbench



---
 rtl/key_event_decoder.sv | 141 ++++++++++++++
 tb/tb_key_event_decoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Single-key gesture decoder: short click, double click, long press, hold.
// Optional auto-repeat while held: define KEY_REPEAT_EN.
module key_event_decoder #(
  parameter logic [23:0] LONG_NUM   = 24'd12000000,
  parameter logic [23:0] DBL_NUM    = 24'd3600000,
  parameter logic [23:0] REPEAT_NUM = 24'd2400000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_jit,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic key_hold,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    LONG
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [23:0] cnt;
  logic [23:0] cnt_nx;
  logic        sp_nx;
  logic        dp_nx;
  logic        lp_nx;

  if (LONG_NUM < 24'd2 || DBL_NUM < 24'd2 || REPEAT_NUM < 24'd2) begin : g_bad
    $error("key_event_decoder: timing parameters must be >= 2");
  end

  // Next state, counter and pulse decode; key edges win over timeouts.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 24'd1;
    sp_nx    = 1'b0;
    dp_nx    = 1'b0;
    lp_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!key_jit) state_nx = PRESS1;
      end
      PRESS1: begin
        if (key_jit) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end else if (cnt == LONG_NUM - 24'd1) begin
          state_nx = LONG;
          cnt_nx   = '0;
          lp_nx    = 1'b1;
        end
      end
      GAP: begin
        if (!key_jit) begin
          state_nx = PRESS2;
          cnt_nx   = '0;
        end else if (cnt == DBL_NUM - 24'd1) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          sp_nx    = 1'b1;
        end
      end
      PRESS2: begin
        if (key_jit) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          dp_nx    = 1'b1;
        end else if (cnt == LONG_NUM - 24'd1) begin
          state_nx = LONG;
          cnt_nx   = '0;
          sp_nx    = 1'b1;
          lp_nx    = 1'b1;
        end
      end
      LONG: begin
        cnt_nx = '0;
        if (key_jit) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      key_hold     <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      short_pulse  <= sp_nx;
      double_pulse <= dp_nx;
      long_pulse   <= lp_nx;
      key_hold     <= (state_nx == LONG);
    end
  end

`ifdef KEY_REPEAT_EN
  logic [23:0] rcnt;
  logic [23:0] rcnt_nx;
  logic        rp_nx;

  // Repeat timer runs only while the long press is still held.
  always_comb begin
    rcnt_nx = '0;
    rp_nx   = 1'b0;
    if (state == LONG && !key_jit) begin
      if (rcnt == REPEAT_NUM - 24'd1) rp_nx = 1'b1;
      else rcnt_nx = rcnt + 24'd1;
    end
  end

  // Repeat counter and pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt         <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rcnt         <= rcnt_nx;
      repeat_pulse <= rp_nx;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder.
// Key waveforms are scored against a run-length gesture model.
module tb_key_event_decoder;

  localparam int LN   = 16;
  localparam int DN   = 8;
  localparam int RN   = 4;
  localparam int MAXT = 512;

  logic clk;
  logic rst_n;
  logic key_jit;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic key_hold;
  logic repeat_pulse;

  bit       wave[MAXT];
  logic [4:0] obs[MAXT];
  logic [4:0] ex[MAXT];
  int       len;
  int       n_chk;
  int       n_fail;

  key_event_decoder #(
    .LONG_NUM  (24'd16),
    .DBL_NUM   (24'd8),
    .REPEAT_NUM(24'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_jit     (key_jit),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .key_hold    (key_hold),
    .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {short_pulse, double_pulse, long_pulse,
            key_hold, repeat_pulse};
  endfunction

  task automatic clear_wave();
    len = 0;
  endtask

  task automatic push(bit v, int n);
    for (int i = 0; i < n; i++)
      if (len < MAXT) begin
        wave[len] = v;
        len++;
      end
  endtask

  function automatic int run_len(int s, bit v);
    int i;
    i = s;
    while (i < len && wave[i] == v) i++;
    return i - s;
  endfunction

  function automatic void mark(int idx, int b);
    if (idx >= 0 && idx < len) ex[idx][b] = 1'b1;
  endfunction

  // Long press from edge a, released at edge b.
  function automatic void mark_long(int a, int b);
    mark(a, 2);
    for (int i = a; i < b; i++) mark(i, 1);
`ifdef KEY_REPEAT_EN
    for (int k = 1; a + RN * k < b; k++) mark(a + RN * k, 0);
`endif
  endfunction

  // Gesture model over run lengths of the sampled key level.
  // Bits: {short, double, long, hold, repeat}.
  function automatic void model();
    int t, t0, l1, r, g, p, l2;
    for (int i = 0; i < MAXT; i++) ex[i] = '0;
    t = 0;
    while (t < len) begin
      if (wave[t]) begin
        t++;
        continue;
      end
      t0 = t;
      l1 = run_len(t0, 1'b0);
      if (l1 > LN) begin
        mark_long(t0 + LN, t0 + l1);
        t = t0 + l1;
        continue;
      end
      r = t0 + l1;
      if (r >= len) break;
      g = run_len(r, 1'b1);
      if (g > DN) begin
        mark(r + DN, 4);
        t = r + DN;
        continue;
      end
      p  = r + g;
      if (p >= len) break;
      l2 = run_len(p, 1'b0);
      if (l2 > LN) begin
        mark(p + LN, 4);
        mark_long(p + LN, p + l2);
      end else begin
        mark(p + l2, 3);
      end
      t = p + l2;
    end
  endfunction

  // Drives wave[] one sample per edge, capturing outputs after each edge.
  task automatic play();
    for (int t = 0; t < len; t++) begin
      key_jit = wave[t];
      @(posedge clk);
      #1 obs[t] = outs();
    end
    key_jit = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    key_jit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (outs() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state got %b exp %b", outs(), 5'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_short_click();
    clear_wave();
    push(1, 2); push(0, 5); push(1, 24);
    model();
    play();
    for (int t = 0; t < len; t++) begin
      n_chk++;
      if (obs[t] !== ex[t]) begin
        n_fail++;
        $display("FAIL short_click t=%0d got %b exp %b", t, obs[t], ex[t]);
      end
    end
    n_chk++;
    if (obs[15] !== 5'b10000) begin
      n_fail++;
      $display("FAIL short_click_time got %b exp %b", obs[15], 5'b10000);
    end
  endtask

  task automatic test_double_click();
    clear_wave();
    push(1, 2); push(0, 3); push(1, 4); push(0, 3); push(1, 24);
    model();
    play();
    for (int t = 0; t < len; t++) begin
      n_chk++;
      if (obs[t] !== ex[t]) begin
        n_fail++;
        $display("FAIL double_click t=%0d got %b exp %b", t, obs[t], ex[t]);
      end
    end
    n_chk++;
    if (obs[12] !== 5'b01000) begin
      n_fail++;
      $display("FAIL double_click_time got %b exp %b", obs[12], 5'b01000);
    end
  endtask

  task automatic test_long_press();
    clear_wave();
    push(1, 2); push(0, 30); push(1, 24);
    model();
    play();
    for (int t = 0; t < len; t++) begin
      n_chk++;
      if (obs[t] !== ex[t]) begin
        n_fail++;
        $display("FAIL long_press t=%0d got %b exp %b", t, obs[t], ex[t]);
      end
    end
    n_chk++;
    if (obs[18] !== 5'b00110 || obs[32] !== 5'b00000) begin
      n_fail++;
      $display("FAIL long_press_edges got %b/%b exp 00110/00000",
               obs[18], obs[32]);
    end
    n_chk++;
`ifdef KEY_REPEAT_EN
    if ({obs[22][0], obs[26][0], obs[30][0], obs[23][0]} !== 4'b1110) begin
      n_fail++;
      $display("FAIL repeat_times got %b exp 1110",
               {obs[22][0], obs[26][0], obs[30][0], obs[23][0]});
    end
`else
    if ({obs[22][0], obs[26][0], obs[30][0]} !== 3'b000) begin
      n_fail++;
      $display("FAIL repeat_tied got %b exp 000",
               {obs[22][0], obs[26][0], obs[30][0]});
    end
`endif
  endtask

  task automatic test_boundaries();
    clear_wave();
    push(1, 2); push(0, 16); push(1, 24);
    model();
    play();
    for (int t = 0; t < len; t++) begin
      n_chk++;
      if (obs[t] !== ex[t]) begin
        n_fail++;
        $display("FAIL release_at_long t=%0d got %b exp %b", t, obs[t], ex[t]);
      end
    end
    n_chk++;
    if (obs[18] !== 5'b00000 || obs[26] !== 5'b10000) begin
      n_fail++;
      $display("FAIL release_at_long_edges got %b/%b exp 00000/10000",
               obs[18], obs[26]);
    end
    clear_wave();
    push(1, 2); push(0, 3); push(1, 8); push(0, 3); push(1, 24);
    model();
    play();
    for (int t = 0; t < len; t++) begin
      n_chk++;
      if (obs[t] !== ex[t]) begin
        n_fail++;
        $display("FAIL press_at_dbl t=%0d got %b exp %b", t, obs[t], ex[t]);
      end
    end
    n_chk++;
    if (obs[13] !== 5'b00000 || obs[16] !== 5'b01000) begin
      n_fail++;
      $display("FAIL press_at_dbl_edges got %b/%b exp 00000/01000",
               obs[13], obs[16]);
    end
  endtask

  task automatic test_press2_long();
    clear_wave();
    push(1, 2); push(0, 3); push(1, 2); push(0, 20); push(1, 24);
    model();
    play();
    for (int t = 0; t < len; t++) begin
      n_chk++;
      if (obs[t] !== ex[t]) begin
        n_fail++;
        $display("FAIL press2_long t=%0d got %b exp %b", t, obs[t], ex[t]);
      end
    end
    n_chk++;
    if (obs[23] !== 5'b10110) begin
      n_fail++;
      $display("FAIL press2_long_edge got %b exp %b", obs[23], 5'b10110);
    end
  endtask

  task automatic test_reset_mid_long();
    key_jit = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_chk++;
    if (key_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_long_hold got %b exp 1", key_hold);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (outs() !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset got %b exp %b", outs(), 5'b0);
    end
    key_jit = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (outs() !== 5'b0) begin
        n_fail++;
        $display("FAIL post_reset k=%0d got %b exp %b", k, outs(), 5'b0);
      end
    end
    rst_n   = 1'b0;
    key_jit = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1 obs[k] = outs();
    end
    n_chk++;
    if (obs[16] !== 5'b00000 || obs[17] !== 5'b00110) begin
      n_fail++;
      $display("FAIL low_at_reset_release got %b/%b exp 00000/00110",
               obs[16], obs[17]);
    end
    key_jit = 1'b1;
    repeat (24) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int lows[10]  = '{1, 2, 3, 5, 15, 16, 17, 20, 25, 30};
    int highs[10] = '{1, 2, 4, 6, 7, 8, 9, 12, 3, 5};
    for (int it = 0; it < 8; it++) begin
      clear_wave();
      push(1, 3);
      for (int g = 0; g < 8; g++) begin
        push(0, lows[$urandom_range(9, 0)]);
        push(1, highs[$urandom_range(9, 0)]);
      end
      push(1, 24);
      model();
      play();
      for (int t = 0; t < len; t++) begin
        n_chk++;
        if (obs[t] !== ex[t]) begin
          n_fail++;
          $display("FAIL random it=%0d t=%0d got %b exp %b",
                   it, t, obs[t], ex[t]);
        end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    @(posedge clk);
    #1;
    test_short_click();
    test_double_click();
    test_long_press();
    test_boundaries();
    test_press2_long();
    test_reset_mid_long();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
